bht_update_arb: RTL and testbench

BHT_UPDATE_ARB -- requirements
Module: bht_update_arb

---
 rtl/bht_update_arb.sv | 100 ++++++++++
 tb/tb_bht_update_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_arb.sv
// Branch-history-table update arbiter: queues up to two resolved branches per
// cycle (br0 older, br1 younger) and issues one registered BHT update per cycle.
module bht_update_arb #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_br0_valid,
    input  logic [31:0]   i_br0_addr,
    input  logic          i_br0_taken,
    output logic          o_br0_ready,
    input  logic          i_br1_valid,
    input  logic [31:0]   i_br1_addr,
    input  logic          i_br1_taken,
    output logic          o_br1_ready,
    input  logic          i_stall,
    input  logic          i_clear,
    output logic          o_update_en,
    output logic [31:0]   o_update_addr,
    output logic          o_update_taken,
    output logic [CW-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] L_LIM0 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] L_LIM1 = CW'(DEPTH - 2);

    logic [31:0]   r_addr  [DEPTH];
    logic          r_taken [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_update_en;
    logic [31:0]   r_update_addr;
    logic          r_update_taken;

    logic          w_push0;
    logic          w_push1;
    logic          w_deq;
    logic [PW-1:0] w_wptr1;
    logic [PW-1:0] w_br1_slot;

    // Handshake: a port transfers on a rising edge where valid && ready.
    // Readies look only at the current occupancy (no credit for a same-cycle
    // dequeue), so br1 being ready always implies br0 is ready too.
    assign o_br0_ready = (r_count <= L_LIM0) && !i_clear;
    assign o_br1_ready = (r_count <= L_LIM1) && !i_clear;

    assign w_push0    = i_br0_valid && o_br0_ready;
    assign w_push1    = i_br1_valid && o_br1_ready;
    assign w_deq      = (r_count != '0) && !i_stall && !i_clear;
    assign w_wptr1    = r_wptr + PW'(1);
    assign w_br1_slot = w_push0 ? w_wptr1 : r_wptr;

    // Queue storage carries no reset; occupancy alone defines valid entries.
    always_ff @(posedge i_clk) begin
        if (w_push0) begin
            r_addr[r_wptr]  <= i_br0_addr;
            r_taken[r_wptr] <= i_br0_taken;
        end
        if (w_push1) begin
            r_addr[w_br1_slot]  <= i_br1_addr;
            r_taken[w_br1_slot] <= i_br1_taken;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_update_en    <= 1'b0;
            r_update_addr  <= 32'h0;
            r_update_taken <= 1'b0;
        end else if (i_clear) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_update_en <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_push0) + PW'(w_push1);
            r_count <= r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_deq);
            if (w_deq) begin
                r_update_en    <= 1'b1;
                r_update_addr  <= r_addr[r_rptr];
                r_update_taken <= r_taken[r_rptr];
                r_rptr         <= r_rptr + PW'(1);
            end else begin
                r_update_en <= 1'b0;
            end
        end
    end

    assign o_update_en    = r_update_en;
    assign o_update_addr  = r_update_addr;
    assign o_update_taken = r_update_taken;
    assign o_count        = r_count;

endmodule

// File: tb/tb_bht_update_arb.sv
// Directed bench for bht_update_arb (DEPTH=4): each task drives one scenario
// and compares outputs against hand-computed values one cycle at a time.
module tb_bht_update_arb;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          br0_valid;
    logic [31:0]   br0_addr;
    logic          br0_taken;
    logic          br0_ready;
    logic          br1_valid;
    logic [31:0]   br1_addr;
    logic          br1_taken;
    logic          br1_ready;
    logic          stall;
    logic          clear;
    logic          upd_en;
    logic [31:0]   upd_addr;
    logic          upd_taken;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    bht_update_arb #(.DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_br0_valid   (br0_valid),
        .i_br0_addr    (br0_addr),
        .i_br0_taken   (br0_taken),
        .o_br0_ready   (br0_ready),
        .i_br1_valid   (br1_valid),
        .i_br1_addr    (br1_addr),
        .i_br1_taken   (br1_taken),
        .o_br1_ready   (br1_ready),
        .i_stall       (stall),
        .i_clear       (clear),
        .o_update_en   (upd_en),
        .o_update_addr (upd_addr),
        .o_update_taken(upd_taken),
        .o_count       (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br0_valid = 1'b0;
        br1_valid = 1'b0;
        br0_addr  = 32'h0;
        br1_addr  = 32'h0;
        br0_taken = 1'b0;
        br1_taken = 1'b0;
    endtask

    task automatic drive0(input logic [31:0] a, input logic t);
        br0_valid = 1'b1;
        br0_addr  = a;
        br0_taken = t;
    endtask

    task automatic drive1(input logic [31:0] a, input logic t);
        br1_valid = 1'b1;
        br1_addr  = a;
        br1_taken = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        clear = 1'b0;
        idle();
        #3;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (upd_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", upd_en); end
        checks++; if (upd_addr !== 32'h0 || upd_taken !== 1'b0) begin errors++; $display("FAIL reset_upd got=%h/%b exp=0/0", upd_addr, upd_taken); end
        checks++; if (br0_ready !== 1'b1 || br1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", br0_ready, br1_ready); end
        #9 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        drive0(32'h100, 1'b1);
        step();
        idle();
        checks++; if (count !== 3'd1 || upd_en !== 1'b0) begin errors++; $display("FAIL single_acc got=%0d/%b exp=1/0", count, upd_en); end
        step();
        checks++; if (upd_en !== 1'b1 || upd_addr !== 32'h100 || upd_taken !== 1'b1) begin errors++; $display("FAIL single_upd got=%b/%h/%b exp=1/100/1", upd_en, upd_addr, upd_taken); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_cnt got=%0d exp=0", count); end
        step();
        checks++; if (upd_en !== 1'b0) begin errors++; $display("FAIL single_once got=%b exp=0", upd_en); end
    endtask

    task automatic test_dual();
        drive0(32'h10, 1'b0);
        drive1(32'h14, 1'b1);
        step();
        idle();
        checks++; if (count !== 3'd2 || upd_en !== 1'b0) begin errors++; $display("FAIL dual_acc got=%0d/%b exp=2/0", count, upd_en); end
        step();
        checks++; if (upd_en !== 1'b1 || upd_addr !== 32'h10 || upd_taken !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL dual_first got=%b/%h/%b/%0d exp=1/10/0/1", upd_en, upd_addr, upd_taken, count); end
        step();
        checks++; if (upd_en !== 1'b1 || upd_addr !== 32'h14 || upd_taken !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL dual_second got=%b/%h/%b/%0d exp=1/14/1/0", upd_en, upd_addr, upd_taken, count); end
        step();
        checks++; if (upd_en !== 1'b0) begin errors++; $display("FAIL dual_end got=%b exp=0", upd_en); end
    endtask

    task automatic test_fill();
        logic [31:0] exp_a [3];
        logic        exp_t [3];
        exp_a[0] = 32'h24; exp_a[1] = 32'h28; exp_a[2] = 32'h2C;
        exp_t[0] = 1'b0;   exp_t[1] = 1'b1;   exp_t[2] = 1'b1;
        stall = 1'b1;
        drive0(32'h20, 1'b1);
        drive1(32'h24, 1'b0);
        step();
        checks++; if (count !== 3'd2 || br0_ready !== 1'b1 || br1_ready !== 1'b1) begin errors++; $display("FAIL fill_two got=%0d/%b%b exp=2/11", count, br0_ready, br1_ready); end
        drive0(32'h28, 1'b1);
        drive1(32'h2C, 1'b1);
        step();
        idle();
        checks++; if (count !== 3'd4 || br0_ready !== 1'b0 || br1_ready !== 1'b0) begin errors++; $display("FAIL fill_full got=%0d/%b%b exp=4/00", count, br0_ready, br1_ready); end
        checks++; if (upd_en !== 1'b0) begin errors++; $display("FAIL fill_stalled got=%b exp=0", upd_en); end
        stall = 1'b0;
        step();
        stall = 1'b1;
        #1;
        checks++; if (upd_en !== 1'b1 || upd_addr !== 32'h20 || upd_taken !== 1'b1) begin errors++; $display("FAIL fill_upd0 got=%b/%h/%b exp=1/20/1", upd_en, upd_addr, upd_taken); end
        checks++; if (count !== 3'd3 || br0_ready !== 1'b1 || br1_ready !== 1'b0) begin errors++; $display("FAIL fill_three got=%0d/%b%b exp=3/10", count, br0_ready, br1_ready); end
        step();
        checks++; if (upd_en !== 1'b0 || count !== 3'd3) begin errors++; $display("FAIL fill_hold got=%b/%0d exp=0/3", upd_en, count); end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (upd_en !== 1'b1 || upd_addr !== exp_a[i] || upd_taken !== exp_t[i]) begin errors++; $display("FAIL fill_drain%0d got=%b/%h/%b exp=1/%h/%b", i, upd_en, upd_addr, upd_taken, exp_a[i], exp_t[i]); end
        end
        step();
        checks++; if (upd_en !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fill_empty got=%b/%0d exp=0/0", upd_en, count); end
    endtask

    task automatic test_concurrent();
        stall = 1'b1;
        drive0(32'h40, 1'b0);
        drive1(32'h44, 1'b1);
        step();
        idle();
        stall = 1'b0;
        drive0(32'h48, 1'b1);
        step();
        idle();
        checks++; if (count !== 3'd2 || upd_en !== 1'b1 || upd_addr !== 32'h40) begin errors++; $display("FAIL conc_same got=%0d/%b/%h exp=2/1/40", count, upd_en, upd_addr); end
        step();
        checks++; if (upd_addr !== 32'h44 || upd_taken !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL conc_second got=%h/%b/%0d exp=44/1/1", upd_addr, upd_taken, count); end
        step();
        checks++; if (upd_en !== 1'b1 || upd_addr !== 32'h48 || upd_taken !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL conc_third got=%b/%h/%b/%0d exp=1/48/1/0", upd_en, upd_addr, upd_taken, count); end
        step();
    endtask

    task automatic test_clear();
        stall = 1'b1;
        drive0(32'h50, 1'b0);
        drive1(32'h54, 1'b0);
        step();
        idle();
        drive0(32'h58, 1'b1);
        step();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL clear_pre got=%0d exp=3", count); end
        stall = 1'b0;
        clear = 1'b1;
        drive1(32'h5C, 1'b1);
        #1;
        checks++; if (br0_ready !== 1'b0 || br1_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got=%b%b exp=00", br0_ready, br1_ready); end
        step();
        clear = 1'b0;
        idle();
        checks++; if (count !== 3'd0 || upd_en !== 1'b0) begin errors++; $display("FAIL clear_post got=%0d/%b exp=0/0", count, upd_en); end
        step();
        checks++; if (count !== 3'd0 || upd_en !== 1'b0 || upd_addr !== 32'h48) begin errors++; $display("FAIL clear_quiet got=%0d/%b/%h exp=0/0/48", count, upd_en, upd_addr); end
    endtask

    task automatic test_reset_mid();
        drive0(32'h60, 1'b1);
        drive1(32'h64, 1'b0);
        step();
        idle();
        step();
        checks++; if (upd_en !== 1'b1 || upd_addr !== 32'h60 || count !== 3'd1) begin errors++; $display("FAIL rmid_pre got=%b/%h/%0d exp=1/60/1", upd_en, upd_addr, count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (upd_en !== 1'b0 || count !== 3'd0 || upd_addr !== 32'h0) begin errors++; $display("FAIL rmid_async got=%b/%0d/%h exp=0/0/0", upd_en, count, upd_addr); end
        #2 rst_n = 1'b1;
        step();
        checks++; if (upd_en !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rmid_after got=%b/%0d exp=0/0", upd_en, count); end
        drive0(32'h70, 1'b0);
        step();
        idle();
        step();
        checks++; if (upd_en !== 1'b1 || upd_addr !== 32'h70 || count !== 3'd0) begin errors++; $display("FAIL rmid_fresh got=%b/%h/%0d exp=1/70/0", upd_en, upd_addr, count); end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive0(32'h80 + 32'(4 * i), i[0]);
            step();
            if (i >= 1) begin
                checks++; if (upd_en !== 1'b1 || upd_addr !== 32'h80 + 32'(4 * (i - 1)) || upd_taken !== ~i[0] || count !== 3'd1) begin errors++; $display("FAIL b2b%0d got=%b/%h/%b/%0d exp=1/%h/%b/1", i, upd_en, upd_addr, upd_taken, count, 32'h80 + 32'(4 * (i - 1)), ~i[0]); end
            end
        end
        idle();
        step();
        checks++; if (upd_en !== 1'b1 || upd_addr !== 32'h94 || count !== 3'd0) begin errors++; $display("FAIL b2b_last got=%b/%h/%0d exp=1/94/0", upd_en, upd_addr, count); end
        step();
        checks++; if (upd_en !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", upd_en); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_fill();
        test_concurrent();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
